// File: rtl/vec_dot_unit_if.sv
// Bus between the vector-dot engine and its requester/data-memory side:
// start handshake, operand bases, wide memory read port and result.
interface vec_dot_unit_if;
    logic         start;
    logic [31:0]  base_a;
    logic [31:0]  base_b;
    logic [31:0]  mem_a;
    logic         mem_req;
    logic [511:0] mem_rd2;
    logic         busy;
    logic         done;
    logic [31:0]  result;

    modport master (
        output start, base_a, base_b, mem_rd2,
        input  mem_a, mem_req, busy, done, result
    );

    modport slave (
        input  start, base_a, base_b, mem_rd2,
        output mem_a, mem_req, busy, done, result
    );
endinterface

// File: rtl/vec_dot_unit.sv
// 16-element signed dot product: two wide fetches, then LANES multiplies
// per cycle into a modulo-2^32 accumulator; result returned with a done pulse.

module vec_dot_lane (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] prod
);
    // Low 32 bits of a product are identical for signed and unsigned operands.
    assign prod = a * b;
endmodule

module vec_dot_unit #(
    parameter int LANES = 4
) (
    input  logic           clk,
    input  logic           rst,
    vec_dot_unit_if.slave  bus
);
    localparam int NELEM = 16;
    localparam int STEPS = NELEM / LANES;
    localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        MAC,
        DONE
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [31:0]                base_a_q;
    logic [31:0]                base_b_q;
    logic [NELEM-1:0][31:0]     vec_a;
    logic [NELEM-1:0][31:0]     vec_b;
    logic [31:0]                acc;
    logic [31:0]                result_q;
    logic [KW-1:0]              k;
    logic [3:0]                 idx0;
    logic [LANES-1:0][31:0]     op_a;
    logic [LANES-1:0][31:0]     op_b;
    logic [LANES-1:0][31:0]     prod;
    logic [31:0]                lane_sum;
    logic                       last_step;
    logic                       busy;
    logic                       done;
    logic                       mem_req;
    logic [31:0]                mem_a;

    // First element handled by this MAC step.
    assign idx0      = 4'(int'(k) * LANES);
    assign last_step = (k == KW'(STEPS - 1));

    for (genvar j = 0; j < LANES; j++) begin : g_sel
        assign op_a[j] = vec_a[idx0 + 4'(j)];
        assign op_b[j] = vec_b[idx0 + 4'(j)];
    end

    vec_dot_lane u_lane [LANES-1:0] (
        .a    (op_a),
        .b    (op_b),
        .prod (prod)
    );

    always_comb begin
        lane_sum = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_sum = lane_sum + prod[j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory address and status are decoded from the registered state only.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_a     = '0;
        case (state)
            IDLE: begin
                state_nxt = bus.start ? FETCH_A : IDLE;
            end
            FETCH_A: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_a     = base_a_q;
                state_nxt = FETCH_B;
            end
            FETCH_B: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_a     = base_b_q;
                state_nxt = MAC;
            end
            MAC: begin
                busy      = 1'b1;
                state_nxt = last_step ? DONE : MAC;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = bus.start ? FETCH_A : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_a_q <= '0;
            base_b_q <= '0;
            vec_a    <= '0;
            vec_b    <= '0;
            acc      <= '0;
            k        <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        base_a_q <= {bus.base_a[31:2], 2'b00};
                        base_b_q <= {bus.base_b[31:2], 2'b00};
                    end
                end
                FETCH_A: begin
                    vec_a <= bus.mem_rd2;
                end
                FETCH_B: begin
                    vec_b <= bus.mem_rd2;
                    acc   <= '0;
                    k     <= '0;
                end
                MAC: begin
                    acc <= acc + lane_sum;
                    k   <= k + 1'b1;
                    if (last_step) begin
                        result_q <= acc + lane_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.mem_req = mem_req;
    assign bus.mem_a   = mem_a;
    assign bus.result  = result_q;
endmodule

// File: tb/tb_vec_dot_unit.sv
// Directed bench for vec_dot_unit: one instance per legal LANES value sharing
// the same start/base inputs and memory image, each with its own read port.
module tb_vec_dot_unit;
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [31:0] base_a;
    logic [31:0] base_b;
    logic [63:0][31:0] ram;

    logic [4:0]        busy_v;
    logic [4:0]        done_v;
    logic [4:0]        req_v;
    logic [4:0][31:0]  res_v;
    logic [4:0][31:0]  addr_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : gd
        vec_dot_unit_if bus ();

        vec_dot_unit #(.LANES(1 << g)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.start  = start;
        assign bus.base_a = base_a;
        assign bus.base_b = base_b;

        always_comb begin
            bus.mem_rd2 = '0;
            for (int i = 0; i < 16; i++) begin
                bus.mem_rd2[i*32 +: 32] = ram[6'(bus.mem_a[31:2]) + 6'(i)];
            end
        end

        assign busy_v[g] = bus.busy;
        assign done_v[g] = bus.done;
        assign req_v[g]  = bus.mem_req;
        assign res_v[g]  = bus.result;
        assign addr_v[g] = bus.mem_a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] a_word, input logic [31:0] b_word, input bit b_ramp);
        for (int i = 0; i < 16; i++) begin
            ram[i]      = a_word;
            ram[16 + i] = b_ramp ? 32'(i + 1) : b_word;
        end
    endtask

    task automatic fill_basic();
        for (int i = 0; i < 64; i++) ram[i] = 32'(i);
    endtask

    // Start one operation on all instances; start stays high for 'hold' edges after E0.
    task automatic run_op(input string tag, input logic [31:0] ba, input logic [31:0] bb,
                          input logic [31:0] exp, input int hold);
        int first[5];
        int cnt[5];
        for (int g = 0; g < 5; g++) begin
            first[g] = -1;
            cnt[g]   = 0;
        end
        base_a = ba;
        base_b = bb;
        start  = 1'b1;
        tick();
        if (hold == 0) start = 1'b0;
        base_a = ~ba;
        base_b = ~bb;
        chk($sformatf("%s.fa_req", tag), 32'(req_v), 32'h1f);
        chk($sformatf("%s.fa_busy", tag), 32'(busy_v), 32'h1f);
        for (int g = 0; g < 5; g++)
            chk($sformatf("%s.fa_addr%0d", tag, g), addr_v[g], {ba[31:2], 2'b00});
        for (int n = 1; n <= 24; n++) begin
            tick();
            if (n == hold) start = 1'b0;
            if (n == 1) begin
                chk($sformatf("%s.fb_req", tag), 32'(req_v), 32'h1f);
                for (int g = 0; g < 5; g++)
                    chk($sformatf("%s.fb_addr%0d", tag, g), addr_v[g], {bb[31:2], 2'b00});
            end
            for (int g = 0; g < 5; g++) begin
                if (done_v[g]) begin
                    cnt[g]++;
                    if (first[g] < 0) begin
                        first[g] = n;
                        chk($sformatf("%s.result%0d", tag, g), res_v[g], exp);
                    end
                end
            end
        end
        for (int g = 0; g < 5; g++) begin
            chk($sformatf("%s.latency%0d", tag, g), 32'(first[g]), 32'(2 + (16 >> g)));
            chk($sformatf("%s.done_count%0d", tag, g), 32'(cnt[g]), 32'd1);
            chk($sformatf("%s.held_result%0d", tag, g), res_v[g], exp);
        end
        chk($sformatf("%s.idle_req", tag), 32'(req_v), 32'h0);
        chk($sformatf("%s.idle_busy", tag), 32'(busy_v), 32'h0);
    endtask

    task automatic b2b();
        int d1[5];
        int d2[5];
        for (int g = 0; g < 5; g++) begin
            d1[g] = -1;
            d2[g] = -1;
        end
        base_a = 32'h0;
        base_b = 32'h0;
        start  = 1'b1;
        tick();
        for (int n = 1; n <= 45; n++) begin
            tick();
            if (n == 40) start = 1'b0;
            for (int g = 0; g < 5; g++) begin
                if (done_v[g]) begin
                    if (d1[g] < 0) d1[g] = n;
                    else if (d2[g] < 0) begin
                        d2[g] = n;
                        chk($sformatf("b2b.result%0d", g), res_v[g], 32'd1240);
                    end
                end
            end
        end
        for (int g = 0; g < 5; g++) begin
            chk($sformatf("b2b.first%0d", g), 32'(d1[g]), 32'(2 + (16 >> g)));
            chk($sformatf("b2b.period%0d", g), 32'(d2[g] - d1[g]), 32'(3 + (16 >> g)));
        end
        for (int n = 0; n < 30; n++) tick();
    endtask

    initial begin
        int dcnt;
        rst    = 1'b1;
        start  = 1'b0;
        base_a = '0;
        base_b = '0;
        fill_basic();
        tick();
        tick();
        chk("rst.busy", 32'(busy_v), 32'h0);
        chk("rst.done", 32'(done_v), 32'h0);
        chk("rst.req", 32'(req_v), 32'h0);
        for (int g = 0; g < 5; g++) begin
            chk($sformatf("rst.addr%0d", g), addr_v[g], 32'h0);
            chk($sformatf("rst.result%0d", g), res_v[g], 32'h0);
        end
        rst = 1'b0;
        tick();

        run_op("basic", 32'h0, 32'h0, 32'h000004D8, 0);

        fill(32'hFFFFFFFF, 32'h0, 1'b1);
        run_op("signed", 32'h3, 32'h40, 32'hFFFFFF78, 0);

        fill(32'h10000000, 32'h1, 1'b0);
        run_op("wrap1", 32'h0, 32'h40, 32'h00000000, 0);

        fill(32'h7FFFFFFF, 32'h2, 1'b0);
        run_op("wrap2", 32'h0, 32'h42, 32'hFFFFFFE0, 0);

        fill_basic();
        run_op("handshake", 32'h0, 32'h0, 32'h000004D8, 3);

        b2b();

        // Abort mid-MAC of the 4-lane instance; reset must act without a clock edge.
        fill(32'h3, 32'h5, 1'b0);
        run_op("pre_rst", 32'h0, 32'h40, 32'h000000F0, 0);
        fill_basic();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort.busy", 32'(busy_v), 32'h0);
        chk("abort.done", 32'(done_v), 32'h0);
        chk("abort.req", 32'(req_v), 32'h0);
        for (int g = 0; g < 5; g++)
            chk($sformatf("abort.result%0d", g), res_v[g], 32'h0);
        tick();
        rst = 1'b0;
        dcnt = 0;
        for (int n = 0; n < 25; n++) begin
            tick();
            if (done_v != 5'b0) dcnt++;
        end
        chk("abort.no_done", 32'(dcnt), 32'h0);

        run_op("after_rst", 32'h0, 32'h0, 32'h000004D8, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vec_dot_unit.md
# vec_dot_unit

Sequential 16-element signed dot-product engine sitting directly downstream of the data memory's 512-bit wide read port. On `start` it fetches two 16-word vectors through the memory's address input and wide read data, latches them, and multiply-accumulates them LANES elements per cycle. It returns a 32-bit result with a one-cycle `done` pulse. It is the compute core of the neural extension's vector-dot instruction; an external mux gives it the memory address while `mem_req` is high.

## Interface
- `LANES`, default 4: elements multiplied per MAC cycle. Legal values are 1, 2, 4, 8 and 16 (must divide 16).
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `start` input, 1 bit: request a new dot product. Sampled only in IDLE or DONE.
- `base_a` input, 32 bits: byte address of vector A.
- `base_b` input, 32 bits: byte address of vector B.
- `mem_a` output, 32 bits: address to data memory.
- `mem_req` output, 1 bit: unit owns the memory address this cycle.
- `mem_rd2` input, 512 bits: wide read data. Word i is bits [32*i+31 : 32*i], and is combinational from `mem_a`.
- `busy` output, 1 bit: operation in progress (FETCH_A, FETCH_B or MAC).
- `done` output, 1 bit: one-cycle pulse; `result` is valid when it is high.
- `result` output, 32 bits: last completed dot product, held until the next `done`.

## Operation
- FSM states: IDLE, FETCH_A, FETCH_B, MAC, DONE.
- IDLE or DONE, with `start`=1:
  - latch `base_a`/`base_b` with bits [1:0] forced to 0;
  - go to FETCH_A.
- IDLE or DONE, with `start`=0: go to (or stay in) IDLE.
- FETCH_A:
  - `mem_a`=latched base A, `mem_req`=1;
  - capture `mem_rd2` into vec_a at the edge;
  - go to FETCH_B.
- FETCH_B:
  - `mem_a`=latched base B, `mem_req`=1;
  - capture `mem_rd2` into vec_b;
  - clear the accumulator and the lane counter k;
  - go to MAC.
- MAC: acc <= acc + sum over j=0..LANES-1 of (vec_a[k*LANES+j] * vec_b[k*LANES+j]).
  - k increments each cycle.
  - When k = 16/LANES-1: load `result` with the final sum and go to DONE.
- DONE: `done`=1 for this single cycle. `start` in this cycle is accepted, which allows back-to-back operations.
- Arithmetic:
  - operands are signed 32-bit;
  - each product is truncated to its low 32 bits;
  - all additions are modulo 2^32, with no saturation and no overflow flag.
- Idle outputs: `mem_a`=0 and `mem_req`=0 in IDLE, MAC and DONE.
- `start` in FETCH_A, FETCH_B or MAC is ignored, with no queuing.
- Changes to `base_a`/`base_b` after the accepting edge have no effect.
- Address range: the caller guarantees that base/4+15 lies within memory. The unit does not check it.

## Timing
- Reset values (asserted at any time, including mid-operation):
  - state=IDLE immediately (asynchronous);
  - `busy`=0, `done`=0, `mem_req`=0, `mem_a`=0, `result`=0;
  - vec_a, vec_b, acc and k are cleared.
  - No `done` pulse is produced for an aborted operation.
- Let edge E0 be the edge that accepts `start`. Then:
  - FETCH_A occupies the cycle after E0;
  - FETCH_B occupies the cycle after E0+1;
  - MAC occupies 16/LANES cycles;
  - DONE begins after edge E0+2+16/LANES (LANES=4 gives E0+6; LANES=1 gives E0+18).
- `busy` rises after E0 and falls together with the rise of `done`.
- `result` updates on the same edge that raises `done`.
- Back-to-back: `start` held high continuously gives one `done` every 3+16/LANES cycles.
- `mem_a` and `mem_req` are decoded from registered state only. There is no combinational path from `start` to `mem_a`.

## Test plan
- Reset: assert `rst` mid-MAC → in the same cycle `busy`=0, `mem_req`=0, `result`=0. No `done` follows; a subsequent operation returns the correct value.
- Basic: memory RAM[j]=j for j=0..15, base_a=0, base_b=0, LANES=4 → `done` one cycle after edge E0+6, `result`=0x000004D8 (1240). `mem_a`=0 during FETCH_A and FETCH_B.
- Signed: A words all 0xFFFFFFFF, B words 1..16 at base 0x40 → `result`=0xFFFFFF78 (-136).
- Wrap: A words all 0x10000000, B words all 1 → `result`=0x00000000. A words all 0x7FFFFFFF, B words all 2 → `result`=0xFFFFFFE0.
- Handshake: pulse `start` again during FETCH_B and during MAC → ignored, exactly one `done`. Hold `start` high across DONE → second operation accepted, next `done` 7 cycles later.
- Parameter sweep: repeat the Basic scenario with LANES=1, 2, 8 and 16 → `result`=1240, `done` after edges E0+18, E0+10, E0+4 and E0+3 respectively.
